vec_adder_stream: RTL and testbench
===================================

Name: vec_adder_stream

Overview:
Streaming, time-multiplexed successor to the fully parallel vector adder. A DIMENTION-element signed vector pair arrives as DIMENTION/LANES beats of LANES elements each. Each beat is added lane-wise through a registered stage with valid/ready backpressure. Width growth is handled by configurable saturate or wrap, with overflow reporting. The block sits between the activation/residual buffers and the layer-norm stage in the transformer datapath.

Parameters:
DIMENTION, 768, total elements per vector; must be divisible by LANES; the quotient must be >= 2.
LANES, 16, elements processed per beat.
WIDTH_ADDEND, 8, signed width of each addend element.
WIDTH_SUM, 8, signed width of each sum element.
SATURATE, 1, 1 = clamp on overflow, 0 = two's-complement wrap.
BEATS (localparam), DIMENTION/LANES.
IDX_W (localparam), max(1, $clog2(BEATS)).

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input beat valid
in_ready  out  1  block can accept a beat
addend1  in  WIDTH_ADDEND*LANES  lane i occupies bits [(i+1)*WIDTH_ADDEND-1 : i*WIDTH_ADDEND], signed
addend2  in  WIDTH_ADDEND*LANES  same packing as addend1
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts the beat
sum  out  WIDTH_SUM*LANES  lane i occupies bits [(i+1)*WIDTH_SUM-1 : i*WIDTH_SUM], signed
out_beat_idx  out  IDX_W  beat index within the vector, 0..BEATS-1
out_last  out  1  high with the final beat of a vector (out_beat_idx == BEATS-1)
ovf_sticky  out  1  sticky flag: some lane overflowed since the last clear
ovf_clr  in  1  synchronous clear of ovf_sticky

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, sum=0, out_beat_idx=0, out_last=0, ovf_sticky=0, input beat counter=0.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - A beat is accepted when in_valid && in_ready.
  - A beat is emitted when out_valid && out_ready.
- Latency: an accepted beat appears on sum/out_valid on the next rising edge (1 cycle).
- Output registers hold stable while out_valid && !out_ready.
- Full throughput of one beat per cycle is sustained when out_ready stays high.
- If no beat is accepted and the current output beat is emitted, out_valid falls to 0. sum holds its last value.
- Beat counter:
  - Increments on each accepted beat and wraps from BEATS-1 to 0.
  - Its value at acceptance is registered into out_beat_idx.
  - out_last = (registered idx == BEATS-1).
  - The counter does not advance on stalled cycles.
- Arithmetic, per lane:
  - s = addend1_lane + addend2_lane, computed exactly at WIDTH_ADDEND+1 bits, signed.
  - If WIDTH_SUM >= WIDTH_ADDEND+1: sum lane = sign-extended s; overflow is never possible.
  - Else if SATURATE=1: clamp to [-2^(WIDTH_SUM-1), 2^(WIDTH_SUM-1)-1].
  - Else: keep the low WIDTH_SUM bits of s.
  - Lane overflow = the representable result differs from s.
- ovf_sticky:
  - Set on the clock edge that registers a beat in which any lane overflowed.
  - Cleared by ovf_clr. If set and clear occur in the same cycle, set wins.
  - Unaffected by stalls.
- Reset mid-vector discards any in-flight beat. The next accepted beat is beat 0.
- Inputs are ignored while in_ready=0. Data on non-accepted cycles never reaches sum.

Test Plan:
- SATURATE=1, all lanes 100+100 then -100+-100 -> sum lanes 127 then -128; ovf_sticky=1 after the first beat; ovf_clr pulse -> 0.
- SATURATE=0, all lanes 100+100 -> sum lanes -56 (0xC8); ovf_sticky=1. Lanes 3+(-5) -> -2 with no new overflow.
- WIDTH_SUM=9, 127+127 -> 254 and -128+-128 -> -256; ovf_sticky stays 0.
- 48 back-to-back beats (DIMENTION 768, LANES 16) with out_ready=1 -> out_valid continuous; out_beat_idx 0..47; out_last only on beat 47. The 49th beat returns idx 0.
- out_ready held low for 5 cycles with a beat pending -> in_ready=0; sum/out_beat_idx stable. Release -> no beat lost or duplicated, order preserved.
- Assert rst_n low after beat 10, deassert, stream again -> all outputs at reset values during reset; the first output after reset has out_beat_idx=0.

Source files
------------

// File: rtl/vec_adder_stream.sv
// rtl/vec_adder_stream.sv - streaming lane-wise signed vector adder with saturate/wrap and overflow flag
module vec_adder_stream #(
  parameter int DIMENTION    = 768,
  parameter int LANES        = 16,
  parameter int WIDTH_ADDEND = 8,
  parameter int WIDTH_SUM    = 8,
  parameter bit SATURATE     = 1'b1,
  localparam int BEATS       = DIMENTION / LANES,
  localparam int IDX_W       = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WIDTH_ADDEND*LANES-1:0] addend1,
  input  logic [WIDTH_ADDEND*LANES-1:0] addend2,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WIDTH_SUM*LANES-1:0]    sum,
  output logic [IDX_W-1:0]              out_beat_idx,
  output logic                          out_last,
  output logic                          ovf_sticky,
  input  logic                          ovf_clr
);

  localparam int WA = WIDTH_ADDEND;
  localparam int WS = WIDTH_SUM;

  logic [WS*LANES-1:0] sum_next;
  logic [LANES-1:0]    lane_ovf;
  logic [IDX_W-1:0]    beat_cnt;
  logic                accept;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic signed [WA-1:0] a;
    logic signed [WA-1:0] b;
    logic signed [WA:0]   s;

    assign a = addend1[i*WA +: WA];
    assign b = addend2[i*WA +: WA];
    assign s = {a[WA-1], a} + {b[WA-1], b};

    if (WS >= WA + 1) begin : g_wide
      assign sum_next[i*WS +: WS] = WS'(s);
      assign lane_ovf[i]          = 1'b0;
    end else begin : g_narrow
      logic [WS-1:0]      low;
      logic signed [WA:0] back;

      // Overflow iff the truncated value does not sign-extend back to the exact sum.
      assign low         = s[WS-1:0];
      assign back        = (WA+1)'($signed(low));
      assign lane_ovf[i] = (back != s);

      if (SATURATE) begin : g_sat
        assign sum_next[i*WS +: WS] = !lane_ovf[i] ? low :
                                      s[WA] ? {1'b1, {(WS-1){1'b0}}} : {1'b0, {(WS-1){1'b1}}};
      end else begin : g_wrap
        assign sum_next[i*WS +: WS] = low;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      sum          <= '0;
      out_beat_idx <= '0;
      out_last     <= 1'b0;
      beat_cnt     <= '0;
    end else if (accept) begin
      out_valid    <= 1'b1;
      sum          <= sum_next;
      out_beat_idx <= beat_cnt;
      out_last     <= (beat_cnt == IDX_W'(BEATS - 1));
      beat_cnt     <= (beat_cnt == IDX_W'(BEATS - 1)) ? '0 : beat_cnt + 1'b1;
    end else if (out_ready) begin
      out_valid    <= 1'b0;
    end
  end

  // Set has priority over clear so an overflow in the clearing cycle is not lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_sticky <= 1'b0;
    end else if (accept && (|lane_ovf)) begin
      ovf_sticky <= 1'b1;
    end else if (ovf_clr) begin
      ovf_sticky <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vec_adder_stream.sv
// tb/tb_vec_adder_stream.sv - randomized self-checking bench for vec_adder_stream (saturate, wrap, 9-bit sum)
module tb_vec_adder_stream;

  localparam int BEATS = 48;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         out_ready;
  logic         ovf_clr;
  logic [127:0] addend1;
  logic [127:0] addend2;

  logic         ir_s, ir_w, ir_x;
  logic         ov_s, ov_w, ov_x;
  logic [127:0] sum_s, sum_w;
  logic [143:0] sum_x;
  logic [5:0]   idx_s, idx_w, idx_x;
  logic         last_s, last_w, last_x;
  logic         ovf_s, ovf_w, ovf_x;

  always #5 clk = ~clk;

  vec_adder_stream #(.SATURATE(1'b1), .WIDTH_SUM(8)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir_s),
    .addend1(addend1), .addend2(addend2), .out_valid(ov_s), .out_ready(out_ready),
    .sum(sum_s), .out_beat_idx(idx_s), .out_last(last_s), .ovf_sticky(ovf_s), .ovf_clr(ovf_clr));

  vec_adder_stream #(.SATURATE(1'b0), .WIDTH_SUM(8)) u_wrap (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir_w),
    .addend1(addend1), .addend2(addend2), .out_valid(ov_w), .out_ready(out_ready),
    .sum(sum_w), .out_beat_idx(idx_w), .out_last(last_w), .ovf_sticky(ovf_w), .ovf_clr(ovf_clr));

  vec_adder_stream #(.SATURATE(1'b1), .WIDTH_SUM(9)) u_wide (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir_x),
    .addend1(addend1), .addend2(addend2), .out_valid(ov_x), .out_ready(out_ready),
    .sum(sum_x), .out_beat_idx(idx_x), .out_last(last_x), .ovf_sticky(ovf_x), .ovf_clr(ovf_clr));

  typedef struct {
    logic [127:0] s;
    logic [127:0] w;
    logic [143:0] x;
    int           idx;
  } beat_t;

  beat_t        q[$];
  beat_t        last_out;
  int           exp_cnt;
  bit           exp_sticky;
  int           checks;
  int           errors;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    exp_cnt      = 0;
    exp_sticky   = 1'b0;
    last_out.s   = '0;
    last_out.w   = '0;
    last_out.x   = '0;
    last_out.idx = 0;
  endtask

  // Plain integer arithmetic: exact sum, then clamp / modulo-256 / keep as 9-bit.
  task automatic model_beat(output beat_t b, output bit ovf);
    byte ba, bb;
    int  s, c, w;
    ovf = 1'b0;
    for (int i = 0; i < 16; i++) begin
      ba = addend1[i*8 +: 8];
      bb = addend2[i*8 +: 8];
      s  = int'(ba) + int'(bb);
      c  = (s > 127) ? 127 : (s < -128) ? -128 : s;
      w  = (s > 127) ? s - 256 : (s < -128) ? s + 256 : s;
      if (s != c) ovf = 1'b1;
      b.s[i*8 +: 8] = c[7:0];
      b.w[i*8 +: 8] = w[7:0];
      b.x[i*9 +: 9] = s[8:0];
    end
    b.idx = exp_cnt;
  endtask

  // Inputs are set at a negedge; checks run 1 time unit later, then advance one cycle.
  task automatic step();
    bit    acc, ovf;
    beat_t nb;
    #1;
    acc = rst_n && in_valid && (q.size() == 0 || out_ready);
    check("ovf_sat", ovf_s, exp_sticky);
    check("ovf_wrap", ovf_w, exp_sticky);
    check("ovf_wide", ovf_x, 1'b0);
    check("out_valid", {ov_s, ov_w, ov_x}, {3{q.size() != 0}});
    check("in_ready", {ir_s, ir_w, ir_x}, {3{q.size() == 0 || out_ready}});
    if (!rst_n) begin
      check("rst_idx", {idx_s, last_s}, 7'd0);
    end
    if (q.size() != 0) begin
      check("sum_sat", sum_s, q[0].s);
      check("sum_wrap", sum_w, q[0].w);
      check("sum_wide", sum_x, q[0].x);
      check("beat_idx", {idx_s, idx_w, idx_x}, {3{6'(q[0].idx)}});
      check("out_last", {last_s, last_w, last_x}, {3{q[0].idx == BEATS - 1}});
      if (out_ready) begin
        last_out = q[0];
        void'(q.pop_front());
      end
    end else begin
      check("hold_sat", sum_s, last_out.s);
      check("hold_wrap", sum_w, last_out.w);
      check("hold_wide", sum_x, last_out.x);
    end
    if (acc) begin
      model_beat(nb, ovf);
      q.push_back(nb);
      exp_cnt = (exp_cnt + 1) % BEATS;
    end else begin
      ovf = 1'b0;
    end
    if (acc && ovf) exp_sticky = 1'b1;
    else if (ovf_clr && rst_n) exp_sticky = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_const(input int a, input int b);
    logic [7:0] a8, b8;
    a8 = a[7:0];
    b8 = b[7:0];
    addend1  = {16{a8}};
    addend2  = {16{b8}};
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic rand_data();
    addend1 = {$urandom, $urandom, $urandom, $urandom};
    addend2 = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic pulse_reset(input int cycles);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    model_reset();
    for (int i = 0; i < cycles; i++) step();
    rst_n = 1'b1;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    ovf_clr   = 1'b0;
    addend1   = '0;
    addend2   = '0;
    model_reset();
    @(negedge clk);
    pulse_reset(3);
    step();

    send_const(100, 100);
    send_const(-100, -100);
    step();
    step();
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    step();
    send_const(3, -5);
    step();
    send_const(127, 127);
    send_const(-128, -128);
    step();
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    step();

    pulse_reset(2);
    for (int i = 0; i < BEATS + 1; i++) begin
      rand_data();
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    step();

    rand_data();
    in_valid = 1'b1;
    step();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rand_data();
      step();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rand_data();
      step();
    end
    in_valid = 1'b0;
    step();

    for (int i = 0; i < 400; i++) begin
      rand_data();
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(3) != 0);
      ovf_clr   = ($urandom_range(15) == 0);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    ovf_clr   = 1'b0;
    step();

    pulse_reset(1);
    for (int i = 0; i < 11; i++) begin
      rand_data();
      in_valid = 1'b1;
      step();
    end
    pulse_reset(2);
    for (int i = 0; i < 6; i++) begin
      rand_data();
      in_valid  = 1'b1;
      out_ready = ($urandom_range(3) != 0);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
